// File: rtl/apb_beat_master.sv
// APB-side beat master for the AXI2APB bridge: issues one APB transfer per burst beat,
// moving data between the write/read FIFOs and the completer.
module apb_beat_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_start,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    wdata_empty,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    wdata_pop,
  input  logic                    rdata_full,
  output logic                    rdata_push,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_resp,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int MASK_WIDTH = STRB_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, PREP, SETUP, ACCESS, DONE} state_t;

  state_t state, state_next;

  logic                  write_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [3:0]            beat_cnt;
  logic                  err_acc;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] byte_off;
  logic [MASK_WIDTH-1:0] strb_mask;
  logic [STRB_WIDTH-1:0] strb_next;
  logic                  wrap_ok;

  // Next beat address and the byte lanes of the current beat (offset aligned down to the beat size).
  always_comb begin
    inc       = ADDR_WIDTH'(1) << size_q;
    wrap_mask = (ADDR_WIDTH'({1'b0, len_q} + 5'd1) << size_q) - ADDR_WIDTH'(1);
    wrap_ok   = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);
    case (burst_q)
      2'd0:    addr_next = paddr_q;
      2'd2:    addr_next = wrap_ok ? ((paddr_q & ~wrap_mask) | ((paddr_q + inc) & wrap_mask))
                                   : (paddr_q + inc);
      default: addr_next = paddr_q + inc;
    endcase
    byte_off  = paddr_q & ADDR_WIDTH'(STRB_WIDTH - 1) & ~(inc - ADDR_WIDTH'(1));
    strb_mask = (MASK_WIDTH'(1) << inc) - MASK_WIDTH'(1);
    strb_next = strb_mask[STRB_WIDTH-1:0] << byte_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    wdata_pop  = 1'b0;
    rdata_push = 1'b0;
    case (state)
      IDLE:   if (cmd_start) state_next = PREP;
      PREP: begin
        if (write_q ? !wdata_empty : !rdata_full) begin
          wdata_pop  = write_q;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          rdata_push = !write_q;
          state_next = (beat_cnt == 4'd0) ? DONE : PREP;
        end
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, per-beat APB payload and the beat/error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      err_acc  <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_start) begin
            write_q  <= cmd_write;
            len_q    <= cmd_len;
            size_q   <= cmd_size;
            burst_q  <= cmd_burst;
            beat_cnt <= cmd_len;
            paddr_q  <= cmd_addr;
            err_acc  <= 1'b0;
            pstrb_q  <= '0;
          end
        end
        PREP: begin
          if (state_next == SETUP) begin
            if (write_q) begin
              pwdata_q <= wdata;
              pstrb_q  <= strb_next;
            end else begin
              pstrb_q  <= '0;
            end
          end
        end
        ACCESS: begin
          if (pready) begin
            err_acc <= err_acc | pslverr;
            if (beat_cnt != 4'd0) begin
              beat_cnt <= beat_cnt - 4'd1;
              paddr_q  <= addr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return lanes are gated so they read as zero outside a completing read beat.
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = done & err_acc;
  assign psel       = (state == SETUP) || (state == ACCESS);
  assign penable    = (state == ACCESS);
  assign pwrite     = write_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;
  assign rdata      = rdata_push ? prdata : '0;
  assign rdata_resp = rdata_push & pslverr;

endmodule

// File: doc/apb_beat_master.md
# apb_beat_master

APB-side master of the AXI2APB bridge: the counterpart of the AXI reader/writer front ends. For each burst command from the bridge engine, it performs one APB transfer per beat. On writes it pops beat data from the write-data FIFO (filled by the AXI reader). On reads it pushes APB read data and response into the read-data FIFO (drained by the AXI writer). It generates the per-beat address sequence (FIXED/INCR/WRAP) and reports completion with an accumulated slave-error flag.

## Interface
- ADDR_WIDTH, 32, APB/AXI address width
- DATA_WIDTH, 32, APB data width; power of two ≥ 8
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_start  in  1  one-cycle request from engine; sampled only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  4  beats − 1 (AXI encoding, 1–16 beats)
- cmd_size  in  3  log2(bytes/beat); ≤ log2(DATA_WIDTH/8)
- cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- err  out  1  any beat got pslverr; valid while done=1
- wdata_empty  in  1  write FIFO empty
- wdata  in  DATA_WIDTH  write FIFO head (first-word fall-through)
- wdata_pop  out  1  consume write FIFO head
- rdata_full  in  1  read FIFO full
- rdata_push  out  1  push read beat
- rdata  out  DATA_WIDTH  read beat data (= prdata)
- rdata_resp  out  1  read beat slave error (= pslverr)
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB4 write strobes
- prdata  in  DATA_WIDTH, pready  in  1, pslverr  in  1  APB completer response

## Operation
- States: IDLE, PREP, SETUP, ACCESS, DONE.
- **IDLE:** on cmd_start, latch all cmd_* fields, load the beat counter with cmd_len, clear err_acc, and go to PREP. cmd_start outside IDLE is ignored.
- **PREP:** the stall point for each beat.
  - Write: if wdata_empty=0, assert wdata_pop combinationally, register wdata into pwdata, compute pstrb, and go to SETUP. Otherwise hold.
  - Read: if rdata_full=0, go to SETUP; otherwise hold.
- **SETUP:** psel=1, penable=0. Next state is ACCESS.
- **ACCESS:** psel=1, penable=1. Hold while pready=0. On pready=1:
  - OR pslverr into err_acc.
  - Read: rdata_push=1 combinationally in this cycle, with rdata=prdata and rdata_resp=pslverr.
  - If the beat counter is 0, go to DONE. Otherwise decrement the counter, advance the address, and go to PREP.
- **DONE:** done=1 and err=err_acc for one cycle, then IDLE.
- A slave error does not abort the burst. All cmd_len+1 beats are always issued, as AXI requires.
- busy=1 in every state except IDLE.
- paddr, pwrite, pwdata and pstrb are registered and stable from SETUP through the end of ACCESS.
- Address arithmetic, with inc = 1 << size:
  - FIXED: paddr unchanged.
  - INCR, or burst=3: paddr + inc, modulo 2^ADDR_WIDTH.
  - WRAP: wsz = (len+1) << size; next = (paddr & ~(wsz−1)) | ((paddr+inc) & (wsz−1)).
  - WRAP with len not in {1, 3, 7, 15} executes as INCR.
- pstrb (writes): ((1 << inc) − 1) << (paddr mod (DATA_WIDTH/8)), with paddr first aligned down to inc. pstrb is all-zero on reads.
- Reset, including mid-burst: all outputs go to 0, the state returns to IDLE, latched command and counters are cleared, and no done pulse is generated.

## Timing
- cmd_start in cycle 0 gives PREP in cycle 1. With a non-stalled FIFO and pready=1, SETUP is cycle 2, ACCESS is cycle 3, and DONE (done=1) is cycle 4.
- Zero-wait burst of N beats: 3N cycles from PREP entry to the last ACCESS, plus 1 DONE cycle. done is asserted in cycle 3N+1.
- Each pready wait cycle adds 1 cycle. Each FIFO stall cycle in PREP adds 1 cycle.
- There is at most one wdata_pop per beat, always in PREP, never in SETUP or ACCESS.
- A new cmd_start can be accepted no earlier than the cycle after DONE.

## Test plan
- **Single write:** addr 0x40, len 0, size 2, INCR, wdata 0xDEADBEEF available, pready=1 → done in cycle 4; paddr=0x40, pwdata=0xDEADBEEF, pstrb=0xF, 1 pop, err=0.
- **INCR write:** 4 beats from 0x1000, size 2 → paddr sequence 0x1000, 0x1004, 0x1008, 0x100C; 4 pops; done in cycle 13.
- **WRAP read:** 4 beats from 0x1008, size 2 → paddr sequence 0x1008, 0x100C, 0x1000, 0x1004; 4 rdata_push pulses carrying prdata.
- **Narrow FIXED write:** size 0, addr 0x23, 2 beats → paddr 0x23 both beats; pstrb=4'b1000.
- **Stalls:** wdata_empty=1 for 3 cycles, then pready=0 for 2 cycles → PREP held 3 cycles, ACCESS held 3 cycles, no extra pop; psel/paddr stable throughout.
- **Error and reset:** read of 3 beats with pslverr on beat 2 → rdata_resp=0,1,0 and err=1 with done. A separate read burst with rst_n asserted mid-ACCESS → all outputs go to 0 immediately and no done pulse.
